// File: rtl/reg_file_param_if.sv
// reg_file_param_if: bus bundle for the parametrised register file.
//   rd_addr/rd_data : NUM_RD read ports; port i occupies element i of each
//                     packed array, i.e. bits [i*W +: W] of the flat vector
//   wr_en/wr_addr/wr_data : single synchronous write port
//   clr_req/busy/clr_done : soft-clear request and sweep status
//   wr_err          : one-cycle pulse, a write was dropped
//   dbg_sel/dbg_data: registered debug tap
// master = client (decode/test side), slave = register file.
interface reg_file_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int NUM_RD = 2
);
  logic [NUM_RD-1:0][ADDR_W-1:0] rd_addr;
  logic [NUM_RD-1:0][DATA_W-1:0] rd_data;
  logic                          wr_en;
  logic [ADDR_W-1:0]             wr_addr;
  logic [DATA_W-1:0]             wr_data;
  logic                          clr_req;
  logic                          busy;
  logic                          clr_done;
  logic                          wr_err;
  logic [ADDR_W-1:0]             dbg_sel;
  logic [DATA_W-1:0]             dbg_data;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, clr_req, dbg_sel,
    input  rd_data, busy, clr_done, wr_err, dbg_data
  );
  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, clr_req, dbg_sel,
    output rd_data, busy, clr_done, wr_err, dbg_data
  );
endinterface

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised GPR file, N combinational read ports, one
// synchronous write port, optional hardwired-zero R0, sweep-based clear.
//   clk     : clock, all state changes on rising edge
//   clear_n : asynchronous active-low reset, starts a full sweep
//   bus     : reg_file_param_if.slave (read/write/clear/debug signals)
// Parameters: DATA_W, ADDR_W (depth = 2**ADDR_W), NUM_RD (1..4), R0_ZERO.
// Optional feature: define REG_FILE_BYPASS_EN for write-through forwarding
// of an accepted write onto same-cycle reads and the debug capture.

// One read lane: array lookup with busy/R0 masking and optional forwarding.
module reg_file_param_lane #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int R0_ZERO = 1
) (
  input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               busy,
  input  logic                               wr_ok,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic [DATA_W-1:0]                  data
);
`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always_comb begin
    data = mem[addr];
    if (BYP && wr_ok && (addr == wr_addr)) data = wr_data;
    // busy masks everything; R0 masking covers the window before any sweep
    if (busy || ((R0_ZERO != 0) && (addr == '0))) data = '0;
  end
endmodule

module reg_file_param #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 4,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 1
) (
  input logic             clk,
  input logic             clear_n,
  reg_file_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  typedef struct packed {
    logic              vld;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            ptr, ptr_nxt;
  logic                         busy, done;
  wr_req_t                      wr_acc;
  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DATA_W-1:0]            dbg_rd;
  logic                         wr_err_q;
  logic [DATA_W-1:0]            dbg_q;

  // State register; reset lands in SWEEP so the array needs no reset fan-out.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state <= SWEEP;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Next-state: clr_req only matters in IDLE, so it cannot restart a sweep.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    case (state)
      IDLE: if (bus.clr_req) begin
        state_nxt = SWEEP;
        ptr_nxt   = '0;
      end
      SWEEP: begin
        if (&ptr) state_nxt = IDLE;
        else      ptr_nxt   = ptr + ADDR_W'(1);
      end
      default: state_nxt = SWEEP;
    endcase
  end

  // Outputs: done is the last sweep cycle, while busy is still high.
  always_comb begin
    busy        = (state == SWEEP);
    done        = busy && (&ptr);
    wr_acc.vld  = bus.wr_en && (state == IDLE) &&
                  !((R0_ZERO != 0) && (bus.wr_addr == '0));
    wr_acc.addr = bus.wr_addr;
    wr_acc.data = bus.wr_data;
  end

  // Array: sweep clears one entry per cycle, otherwise the accepted write.
  always_ff @(posedge clk) begin
    if (busy)            mem[ptr]         <= '0;
    else if (wr_acc.vld) mem[wr_acc.addr] <= wr_acc.data;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wr_err_q <= 1'b0;
      dbg_q    <= '0;
    end else begin
      wr_err_q <= bus.wr_en && busy;
      dbg_q    <= dbg_rd;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    reg_file_param_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(R0_ZERO)) u_lane (
      .mem     (mem),
      .addr    (bus.rd_addr[g]),
      .busy    (busy),
      .wr_ok   (wr_acc.vld),
      .wr_addr (wr_acc.addr),
      .wr_data (wr_acc.data),
      .data    (bus.rd_data[g])
    );
  end

  reg_file_param_lane #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .R0_ZERO(R0_ZERO)) u_dbg (
    .mem     (mem),
    .addr    (bus.dbg_sel),
    .busy    (busy),
    .wr_ok   (wr_acc.vld),
    .wr_addr (wr_acc.addr),
    .wr_data (wr_acc.data),
    .data    (dbg_rd)
  );

  assign bus.busy     = busy;
  assign bus.clr_done = done;
  assign bus.wr_err   = wr_err_q;
  assign bus.dbg_data = dbg_q;
endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
- Parametrised general-purpose register file; successor to the fixed 16x16 datapath register file.
- Sits between decode and the ALU: N combinational read ports, one synchronous write port, optional hardwired-zero R0.
- Clears by a hardware sweep FSM, one entry per cycle, so no wide reset fan-out into the array.
- Registered debug tap replaces fixed R1/R2/R3 outputs.

Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 4: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports, 1..4.
- R0_ZERO, 1: 1 = entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock, all state changes on rising edge.
- clear_n  in  1  asynchronous active-low reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data, combinational from rd_addr.
- wr_en  in  1  write strobe.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- clr_req  in  1  soft-clear request, level-sampled.
- busy  out  1  sweep in progress.
- clr_done  out  1  one-cycle pulse on the cycle the sweep ends.
- wr_err  out  1  registered one-cycle pulse: a write was dropped.
- dbg_sel  in  ADDR_W  debug tap select.
- dbg_data  out  DATA_W  registered contents of entry dbg_sel.

Behaviour:
- Reset/clock: one clock (clk); reset clear_n is asynchronous and active-low.
- Reset asserted:
  - FSM enters SWEEP with ptr=0 and busy=1.
  - clr_done=0, wr_err=0, dbg_data=0.
  - Array contents are not reset directly.
- FSM states IDLE and SWEEP:
  - SWEEP: each cycle write 0 to entry ptr, then ptr++.
  - When ptr = depth-1: write that entry, go to IDLE, and pulse clr_done on that same cycle.
  - busy is high throughout SWEEP, including the cycle clr_done is high.
  - The sweep takes exactly depth cycles after clear_n deasserts.
  - IDLE with clr_req=1 at a rising edge: go to SWEEP with ptr=0. busy rises the next cycle.
  - clr_req during SWEEP is ignored; it does not restart or extend the sweep.
  - Reset asserted mid-sweep restarts from ptr=0.
- Writes:
  - In IDLE, wr_en=1 writes wr_data to wr_addr at the rising edge.
  - With R0_ZERO=1, a write to entry 0 is silently discarded; this is not an error.
  - wr_en=1 while busy: the write is dropped and wr_err pulses high the following cycle.
  - A write in the same cycle as the IDLE->SWEEP transition (clr_req=1 in IDLE) is performed. The sweep then clears that entry later.
- Reads:
  - Each port is purely combinational: rd_data[i] = entry[rd_addr[i]].
  - R0_ZERO=1 with address 0 returns 0.
  - While busy, all read ports return 0 regardless of array contents.
  - Without the optional feature, a read of the address being written in the same cycle returns the old value.
- Debug tap: dbg_data <= entry[dbg_sel] every cycle, one-cycle latency; 0 while busy.
- Widths: no arithmetic. Out-of-range addresses are impossible because depth is a full power of two.

Optional Feature:
- Macro: REG_FILE_BYPASS_EN.
- Defined: any read port (and the dbg_data capture) whose address equals wr_addr while a write is accepted (wr_en=1, IDLE, not R0 under R0_ZERO) returns wr_data in that same cycle (write-through forwarding).
- Not defined: the same-cycle read returns the pre-write value; the new value is visible from the next cycle.

Test Plan:
1. Reset: clear_n low for 3 cycles, then high. Required: busy=1 for exactly 16 cycles (DATA_W=16, ADDR_W=4), clr_done pulses on cycle 16, all rd_data=0 during and after.
2. Write/read: write 0x1234 to R5, then read R5 on port 0 and R5 on port 1 next cycle. Required: both ports return 0x1234; R0 write of 0xFFFF reads back 0.
3. Write while busy: assert clr_req; two cycles later write 0xBEEF to R3. Required: wr_err=1 for one cycle, R3 reads 0 after clr_done.
4. Reset mid-sweep: pulse clear_n low at sweep cycle 7. Required: sweep restarts; busy stays high for 16 more cycles, and clr_done fires once, not twice.
5. Same-cycle read/write to R9 with 0x00AA (R9 previously 0x0011). Required: rd_data=0x0011 without REG_FILE_BYPASS_EN, 0x00AA with it; both give 0x00AA the next cycle.
6. Debug tap: R2=0x0005, set dbg_sel=2. Required: dbg_data=0x0005 one cycle later and 0 while busy.
